// File: rtl/mem_seq_pkg.sv
// Shared constants for the memory sequencer: opcode values and state encoding.
package mem_seq_pkg;

   // Opcodes that need a data-memory phase
   localparam logic [5:0] OP_LD  = 6'h18;
   localparam logic [5:0] OP_ST  = 6'h19;
   localparam logic [5:0] OP_LDR = 6'h1F;

   // Sequencer states (3-bit encoding)
   typedef enum logic [2:0] {
      S_RST   = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_CHK   = 3'd4,
      S_IRQ   = 3'd5,
      S_TRAP  = 3'd6
   } state_e;

   // True when the opcode must go through the MEM phase
   function automatic logic is_mem_op(input logic [5:0] op_val);
      return (op_val == OP_LD) || (op_val == OP_ST) || (op_val == OP_LDR);
   endfunction

endpackage

// File: rtl/mem_seq_timeout.sv
// Bus-timeout counter: cleared on state entry, counts stalled cycles and
// saturates at TIMEOUT-1, where the terminal-count flag is raised.
module mem_seq_timeout #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins, otherwise increment until the terminal value
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != TC_VAL)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_seq.sv
// Multi-cycle sequencer sharing one single-port memory between instruction
// fetch and data access, with interrupt and bus-timeout traps inserted at
// instruction boundaries.
module mem_seq
   import mem_seq_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic       mwr,
   input  logic       werf,
   input  logic       irq,
   input  logic       pc_super,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_sel,
   output logic       ir_we,
   output logic       pc_we,
   output logic       rf_we,
   output logic       irq_take,
   output logic       trap_take,
   output logic       busy
);

   state_e state_q;
   state_e state_d;
   logic   cnt_clr;
   logic   cnt_en;
   logic   cnt_tc;

   // State register; reset forces RST, which drops every output at once
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_RST;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and outputs; strobes tied to mem_ack are combinational
   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      rf_we     = 1'b0;
      irq_take  = 1'b0;
      trap_take = 1'b0;
      busy      = 1'b0;
      cnt_en    = 1'b0;
      unique case (state_q)
         S_RST: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_we   = 1'b1;
               state_d = S_EXEC;
            end else begin
               cnt_en = 1'b1;
               if (cnt_tc) begin
                  state_d = S_TRAP;
               end
            end
         end
         S_EXEC: begin
            busy = 1'b1;
            if (is_mem_op(op)) begin
               state_d = S_MEM;
            end else begin
               pc_we   = 1'b1;
               rf_we   = werf;
               state_d = S_CHK;
            end
         end
         S_MEM: begin
            busy     = 1'b1;
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = mwr;
            if (mem_ack) begin
               pc_we   = 1'b1;
               rf_we   = werf;
               state_d = S_CHK;
            end else begin
               cnt_en = 1'b1;
               // Abandoned access: nothing architectural is written
               if (cnt_tc) begin
                  state_d = S_TRAP;
               end
            end
         end
         S_CHK: begin
            busy = 1'b1;
            if (irq && !pc_super) begin
               state_d = S_IRQ;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_IRQ: begin
            busy     = 1'b1;
            irq_take = 1'b1;
            pc_we    = 1'b1;
            rf_we    = 1'b1;
            state_d  = S_FETCH;
         end
         S_TRAP: begin
            busy      = 1'b1;
            trap_take = 1'b1;
            pc_we     = 1'b1;
            rf_we     = 1'b1;
            state_d   = S_FETCH;
         end
         default: begin
            state_d = S_RST;
         end
      endcase
   end

   // The counter restarts whenever the sequencer moves to a new state
   assign cnt_clr = (state_d != state_q);

   mem_seq_timeout #(
      .TIMEOUT(TIMEOUT),
      .CNT_W  (CNT_W)
   ) u_timeout (
      .clk    (clk),
      .reset_n(reset_n),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .tc_o   (cnt_tc)
   );

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq: walks each instruction class cycle by cycle and
// compares the full output vector against hand-written per-state patterns.
module tb_mem_seq;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [5:0] op = 6'h20;
   logic       mwr = 1'b0;
   logic       werf = 1'b0;
   logic       irq = 1'b0;
   logic       pc_super = 1'b0;
   logic       mem_ack = 1'b0;
   logic       mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we;
   logic       irq_take, trap_take, busy;

   int checks = 0;
   int errors = 0;

   // Output vector bit order:
   // [8]mem_req [7]mem_we [6]addr_sel [5]ir_we [4]pc_we [3]rf_we
   // [2]irq_take [1]trap_take [0]busy
   localparam logic [8:0] E_ZERO     = 9'b000000000;
   localparam logic [8:0] E_FETCH    = 9'b100000000;
   localparam logic [8:0] E_FETCH_AK = 9'b100100000;
   localparam logic [8:0] E_EXEC_ALU = 9'b000011001;
   localparam logic [8:0] E_EXEC_MEM = 9'b000000001;
   localparam logic [8:0] E_MEM_LD   = 9'b101000001;
   localparam logic [8:0] E_MEM_LDAK = 9'b101011001;
   localparam logic [8:0] E_MEM_STAK = 9'b111010001;
   localparam logic [8:0] E_CHK      = 9'b000000001;
   localparam logic [8:0] E_IRQ      = 9'b000011101;
   localparam logic [8:0] E_TRAP     = 9'b000011011;
   localparam logic [8:0] M_ALL      = 9'h1FF;
   localparam logic [8:0] M_NOBUSY   = 9'h1FE;

   localparam logic [5:0] ADD = 6'h20;
   localparam logic [5:0] LD  = 6'h18;
   localparam logic [5:0] ST  = 6'h19;

   mem_seq #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .op       (op),
      .mwr      (mwr),
      .werf     (werf),
      .irq      (irq),
      .pc_super (pc_super),
      .mem_ack  (mem_ack),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .addr_sel (addr_sel),
      .ir_we    (ir_we),
      .pc_we    (pc_we),
      .rf_we    (rf_we),
      .irq_take (irq_take),
      .trap_take(trap_take),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] outs();
      return {mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we, irq_take, trap_take, busy};
   endfunction

   task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end else begin
         $display("ok   %s out=%b", tag, got);
      end
   endtask

   // One clock cycle: compare at the falling edge, then advance past the rising edge
   task automatic step(input string tag, input logic [8:0] exp, input logic [8:0] mask);
      @(negedge clk);
      check(tag, outs() & mask, exp & mask);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset asserted: everything low
      #12;
      check("reset_held", outs(), E_ZERO);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step("rst_state", E_ZERO, M_ALL);

      // 1: ALU ops with ack tied high, 3 cycles each
      op = ADD; werf = 1'b1; mem_ack = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step($sformatf("add%0d_fetch", i), E_FETCH_AK, M_NOBUSY);
         step($sformatf("add%0d_exec", i), E_EXEC_ALU, M_ALL);
         step($sformatf("add%0d_chk", i), E_CHK, M_ALL);
      end

      // 2: LD with ack two cycles into MEM (ack in EXEC is ignored)
      op = LD; werf = 1'b1;
      step("ld_fetch", E_FETCH_AK, M_NOBUSY);
      step("ld_exec", E_EXEC_MEM, M_ALL);
      mem_ack = 1'b0;
      step("ld_mem0", E_MEM_LD, M_ALL);
      step("ld_mem1", E_MEM_LD, M_ALL);
      mem_ack = 1'b1;
      step("ld_mem_ack", E_MEM_LDAK, M_ALL);
      step("ld_chk", E_CHK, M_ALL);

      // 3: ST with immediate ack, no register-file write
      op = ST; mwr = 1'b1; werf = 1'b0;
      step("st_fetch", E_FETCH_AK, M_NOBUSY);
      step("st_exec", E_EXEC_MEM, M_ALL);
      step("st_mem_ack", E_MEM_STAK, M_ALL);
      step("st_chk", E_CHK, M_ALL);
      mwr = 1'b0;

      // 4: interrupt taken at the boundary, then masked by pc_super
      op = ADD; werf = 1'b1; irq = 1'b1; pc_super = 1'b0;
      step("irq_fetch", E_FETCH_AK, M_NOBUSY);
      step("irq_exec", E_EXEC_ALU, M_ALL);
      step("irq_chk", E_CHK, M_ALL);
      step("irq_take", E_IRQ, M_ALL);
      pc_super = 1'b1;
      step("sup_fetch", E_FETCH_AK, M_NOBUSY);
      step("sup_exec", E_EXEC_ALU, M_ALL);
      step("sup_chk", E_CHK, M_ALL);
      step("sup_fetch2", E_FETCH_AK, M_NOBUSY);
      irq = 1'b0; pc_super = 1'b0;
      step("sup_exec2", E_EXEC_ALU, M_ALL);
      step("sup_chk2", E_CHK, M_ALL);

      // 5: fetch timeout, exactly 16 stalled cycles then TRAP
      mem_ack = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step($sformatf("to_fetch%0d", i), E_FETCH, M_ALL);
      end
      step("to_trap", E_TRAP, M_ALL);

      // Ack on the last allowed cycle still succeeds
      for (int i = 0; i < 15; i++) begin
         step($sformatf("late_fetch%0d", i), E_FETCH, M_ALL);
      end
      mem_ack = 1'b1;
      step("late_fetch_ack", E_FETCH_AK, M_NOBUSY);
      step("late_exec", E_EXEC_ALU, M_ALL);
      step("late_chk", E_CHK, M_ALL);

      // MEM-phase timeout on a load: TRAP, no PC/RF write during MEM
      op = LD;
      step("mto_fetch", E_FETCH_AK, M_NOBUSY);
      step("mto_exec", E_EXEC_MEM, M_ALL);
      mem_ack = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step($sformatf("mto_mem%0d", i), E_MEM_LD, M_ALL);
      end
      step("mto_trap", E_TRAP, M_ALL);
      step("mto_fetch2", E_FETCH, M_ALL);
      mem_ack = 1'b1;
      step("mto_fetch_ack", E_FETCH_AK, M_NOBUSY);
      step("mto_exec2", E_EXEC_MEM, M_ALL);

      // 6: reset in the middle of MEM drops outputs without a clock edge
      mem_ack = 1'b0;
      @(negedge clk);
      check("rmid_mem", outs(), E_MEM_LD);
      #2;
      reset_n = 1'b0;
      #1;
      check("rmid_async", outs(), E_ZERO);
      @(posedge clk);
      #1;
      check("rmid_held", outs(), E_ZERO);
      reset_n = 1'b1;
      step("rmid_rst", E_ZERO, M_ALL);
      step("rmid_fetch", E_FETCH, M_ALL);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_seq.md
Name: mem_seq

Overview:
Multi-cycle sequencer for the RISC datapath when instruction fetch and data access share one single-port memory with a variable-latency ack.
- Sequences fetch / execute / memory phases and generates the register write enables (IR, PC, register file).
- Arbitrates the memory port between the PC (fetch) and the ALU result (LD/ST/LDR).
- Inserts interrupt and bus-timeout traps at instruction boundaries.
- Sits beside the combinational decoder. The decoder's werf/mwr are qualified by this block's strobes.

Parameters:
TIMEOUT, 16, max cycles waiting for mem_ack before a bus-error trap (>=2)
CNT_W, 5, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
op  in  6  opcode field of the instruction register
mwr  in  1  decoder memory-write request for current op
werf  in  1  decoder register-file write request for current op
irq  in  1  level interrupt request
pc_super  in  1  PC supervisor bit (PC[31]); interrupts masked when 1
mem_ack  in  1  memory completes the current access this cycle
mem_req  out  1  memory access active
mem_we  out  1  write strobe, valid with mem_req
addr_sel  out  1  0 = PC drives address, 1 = ALU result drives address
ir_we  out  1  load instruction register
pc_we  out  1  load PC (selection from decoder or trap override)
rf_we  out  1  qualified register-file write
irq_take  out  1  force pcsel=IRQ and wasel=XP this cycle
trap_take  out  1  force pcsel=ILLOP and wasel=XP this cycle
busy  out  1  high except in FETCH before the first ack

Behaviour:
- Reset (reset_n low, asynchronous): state=RST. All outputs 0. Counter cleared.
- The outputs listed per state are the only outputs asserted in that state. All others are 0.
- All outputs are Moore, except strobes qualified by mem_ack, which are combinational.
- RST: one cycle after reset release. busy=0. Next state FETCH.
- FETCH:
  - Outputs: mem_req=1, addr_sel=0, mem_we=0.
  - On mem_ack: ir_we=1, next state EXEC.
  - Otherwise the counter increments. When counter==TIMEOUT-1 and no ack, next state TRAP.
- EXEC: one cycle.
  - If op is LD, ST or LDR, next state MEM.
  - Otherwise: pc_we=1, rf_we=werf, next state CHK.
- MEM:
  - Outputs: mem_req=1, addr_sel=1, mem_we=mwr.
  - On mem_ack: pc_we=1, rf_we=werf, next state CHK. For ST, werf=0, so there is no register-file write.
  - Timeout behaves as in FETCH → TRAP. The store is abandoned; PC and the register file are not written.
- CHK: instruction boundary, one cycle.
  - If irq && !pc_super, next state IRQ.
  - Otherwise next state FETCH. CHK asserts nothing.
- IRQ: irq_take=1, pc_we=1, rf_we=1 (saves PC+4 to XP). Next state FETCH.
- TRAP: trap_take=1, pc_we=1, rf_we=1. Next state FETCH. The bus error is not retried.
- Timeout counter: cleared on every state entry. Saturates; it never wraps.
- Priority and boundary cases:
  - An ack in the same cycle the counter reaches TIMEOUT-1 counts as success.
  - TRAP is taken over IRQ.
  - irq is sampled only in CHK. An irq pulse that falls before CHK is lost; the source must hold the level.
  - mem_ack outside FETCH/MEM is ignored.
- Reset mid-access: mem_req drops asynchronously. Memory must tolerate an abandoned request.
- Throughput: a non-memory instruction takes FETCH(≥1)+EXEC+CHK = 3 cycles minimum. LD/ST take 4 cycles minimum.

Decomposition:
- Opcode constants LD, ST, LDR and the state encoding (RST, FETCH, EXEC, MEM, CHK, IRQ, TRAP; 3-bit) belong in risc_constants.vh.
- One sub-module, mem_timeout: a counter with clear, enable and a terminal-count flag, parameterised by TIMEOUT and CNT_W.

Test Plan:
1. Release reset; op=ADD, werf=1, mem_ack tied 1 → ir_we in cycle 2 after RST. EXEC has pc_we=1, rf_we=1. FETCH repeats every 3 cycles.
2. op=LD (6'h18), werf=1, ack 2 cycles into MEM → MEM holds mem_req=1, addr_sel=1, mem_we=0 for 3 cycles. pc_we and rf_we are asserted with the ack.
3. op=ST (6'h19), mwr=1, werf=0, ack immediate → mem_we=1 for one cycle, rf_we=0, pc_we=1.
4. irq=1, pc_super=0 during an ADD → after CHK, one IRQ cycle with irq_take=1, pc_we=1, rf_we=1. With pc_super=1 there is no irq_take.
5. mem_ack held 0 in FETCH with TIMEOUT=16 → exactly 16 FETCH cycles, then TRAP with trap_take=1 for one cycle, then FETCH. No ir_we.
6. Assert reset_n low during MEM → mem_req and all strobes 0 without waiting for a clock edge. After release, RST then FETCH.
